// File: rtl/uart_tx_mmio_buffer_pkg.sv
// Shared MMIO map and store-decode helpers for the UART TX buffer and the IO memory map.
package uart_tx_mmio_buffer_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned TX_FIFO_DEPTH = 8;

    localparam logic [ADDR_W-1:0] ADDR_UART_CTRL   = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] ADDR_UART_DATA   = 32'h8000_0004;
    localparam logic [ADDR_W-1:0] ADDR_TX_DATA     = 32'h8000_0008;
    localparam logic [ADDR_W-1:0] ADDR_TX_CLR      = 32'h8000_000C;
    localparam logic [ADDR_W-1:0] ADDR_CNT_RESET   = 32'h8000_0010;
    localparam logic [ADDR_W-1:0] ADDR_CNT_READ_LO = 32'h8000_0014;
    localparam logic [ADDR_W-1:0] ADDR_CNT_READ_HI = 32'h8000_0018;

    typedef enum logic [1:0] {
        MMIO_NONE     = 2'd0,
        MMIO_TX_PUSH  = 2'd1,
        MMIO_TX_FLUSH = 2'd2
    } mmio_cmd_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mmio_store_t;

    // A store can hit at most one address, so push and flush are mutually exclusive.
    function automatic mmio_cmd_e mmio_decode(input logic [ADDR_W-1:0] addr, input logic we);
        mmio_cmd_e cmd;
        cmd = MMIO_NONE;
        if (we && addr == ADDR_TX_DATA) cmd = MMIO_TX_PUSH;
        else if (we && addr == ADDR_TX_CLR) cmd = MMIO_TX_FLUSH;
        return cmd;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_buffer_if.sv
// CPU store port, transmitter handshake and software status of the UART TX buffer.
interface uart_tx_mmio_buffer_if
    import uart_tx_mmio_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = TX_FIFO_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_not_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_overflow;

    modport master (
        output mem_addr, mem_we, mem_wdata, tx_ready,
        input  tx_data, tx_valid, tx_not_full, tx_empty, tx_count, tx_overflow
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata, tx_ready,
        output tx_data, tx_valid, tx_not_full, tx_empty, tx_count, tx_overflow
    );

endinterface

// File: rtl/uart_tx_mmio_buffer_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with flush; pointers carry one extra wrap bit.
module uart_tx_mmio_buffer_fifo_sync #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is the registered state, so a pop in the same cycle never makes room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (flush)       rd_ptr <= wr_ptr;
            else if (do_pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_mmio_buffer.sv
// Buffers CPU MMIO byte stores into a FIFO that drains into the UART transmitter.
module uart_tx_mmio_buffer
    import uart_tx_mmio_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = TX_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_mmio_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    mmio_store_t       store;
    mmio_cmd_e         cmd;
    logic              push;
    logic              flush;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              overflow_q;

    assign store = '{addr: bus.mem_addr, we: bus.mem_we, wdata: bus.mem_wdata};
    assign cmd   = mmio_decode(store.addr, store.we);
    assign push  = (cmd == MMIO_TX_PUSH);
    assign flush = (cmd == MMIO_TX_FLUSH);
    assign pop   = !fifo_empty && bus.tx_ready;

    uart_tx_mmio_buffer_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (store.wdata),
        .pop   (pop),
        .flush (flush),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky drop flag; only a flush store or reset clears it.
    always_ff @(posedge clk) begin
        if (rst)                    overflow_q <= 1'b0;
        else if (flush)             overflow_q <= 1'b0;
        else if (push && fifo_full) overflow_q <= 1'b1;
    end

    assign bus.tx_data     = fifo_rdata;
    assign bus.tx_valid    = !fifo_empty;
    assign bus.tx_not_full = !fifo_full;
    assign bus.tx_empty    = fifo_empty;
    assign bus.tx_count    = fifo_count;
    assign bus.tx_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_mmio_buffer.sv
// Scoreboard bench for uart_tx_mmio_buffer: stimulus queues expected bytes, a monitor checks the drain.
module tb_uart_tx_mmio_buffer;
    import uart_tx_mmio_buffer_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_mmio_buffer_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_mmio_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Handshake seen mid-cycle pops at the next edge; compare against the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected no output at %0t", bus.tx_data, $time);
            end else begin
                check("tx_data_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [7:0] data);
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        step();
        bus.mem_we    = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] data);
        if (exp_q.size() < DEPTH) exp_q.push_back(data);
        store(ADDR_TX_DATA, data);
    endtask

    task automatic drain(input string name);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 40 && !bus.tx_empty; i++) step();
        bus.tx_ready = 1'b0;
        check(name, 32'(bus.tx_count), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int pushed;
        logic [7:0] d;

        rst = 1'b1;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        bus.tx_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid",    32'(bus.tx_valid),    32'd0);
        check("rst_count",    32'(bus.tx_count),    32'd0);
        check("rst_not_full", 32'(bus.tx_not_full), 32'd1);
        check("rst_empty",    32'(bus.tx_empty),    32'd1);
        check("rst_overflow", 32'(bus.tx_overflow), 32'd0);

        // Single push, then one-cycle drain
        push_byte(8'h41);
        check("single_valid", 32'(bus.tx_valid), 32'd1);
        check("single_data",  32'(bus.tx_data),  32'h41);
        check("single_count", 32'(bus.tx_count), 32'd1);
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        check("single_pop_count", 32'(bus.tx_count), 32'd0);
        check("single_pop_valid", 32'(bus.tx_valid), 32'd0);

        // Fill to full, then an extra push is dropped
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        check("full_not_full_pre", 32'(bus.tx_not_full), 32'd0);
        push_byte(8'hFF);
        check("ovf_count",    32'(bus.tx_count),    32'd8);
        check("ovf_not_full", 32'(bus.tx_not_full), 32'd0);
        check("ovf_flag",     32'(bus.tx_overflow), 32'd1);
        check("ovf_hold_data", 32'(bus.tx_data),    32'h00);
        drain("ovf_drain");
        check("ovf_sticky", 32'(bus.tx_overflow), 32'd1);

        // Simultaneous push and pop at count 3
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        check("simul_pre_count", 32'(bus.tx_count), 32'd3);
        bus.tx_ready = 1'b1;
        push_byte(8'h55);
        bus.tx_ready = 1'b0;
        check("simul_count", 32'(bus.tx_count), 32'd3);
        drain("simul_drain");

        // Flush at count 5 with overflow still set; other addresses and idle strobes ignored
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        check("flush_pre_count", 32'(bus.tx_count),    32'd5);
        check("flush_pre_ovf",   32'(bus.tx_overflow), 32'd1);
        store(ADDR_TX_CLR, 8'h00);
        exp_q.delete();
        check("flush_count",    32'(bus.tx_count),    32'd0);
        check("flush_valid",    32'(bus.tx_valid),    32'd0);
        check("flush_overflow", 32'(bus.tx_overflow), 32'd0);
        check("flush_empty",    32'(bus.tx_empty),    32'd1);
        store(32'h8000_0010, 8'h99);
        check("other_addr_count", 32'(bus.tx_count), 32'd0);
        check("other_addr_valid", 32'(bus.tx_valid), 32'd0);
        bus.mem_addr = ADDR_TX_DATA;
        bus.mem_wdata = 8'h77;
        step();
        check("no_we_count", 32'(bus.tx_count), 32'd0);

        // Push while full with a pop in the same cycle is still dropped
        for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
        bus.tx_ready = 1'b1;
        push_byte(8'hEE);
        bus.tx_ready = 1'b0;
        check("full_pop_push_count", 32'(bus.tx_count),    32'd7);
        check("full_pop_push_ovf",   32'(bus.tx_overflow), 32'd1);
        drain("full_pop_drain");
        store(ADDR_TX_CLR, 8'h00);
        check("clr_overflow", 32'(bus.tx_overflow), 32'd0);

        // Reset in the middle of a drain discards buffered bytes
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        bus.tx_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.tx_ready = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(bus.tx_count), 32'd0);
        check("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
        check("mid_rst_empty", 32'(bus.tx_empty), 32'd1);

        // Wrap with random backpressure: occupancy tracks the scoreboard every cycle
        pushed = 0;
        for (int cyc = 0; cyc < 400 && (pushed < 20 || !bus.tx_empty); cyc++) begin
            check("wrap_count", 32'(bus.tx_count), 32'(exp_q.size()));
            bus.tx_ready = 1'($urandom_range(0, 1));
            if (pushed < 20 && exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                d = 8'($urandom_range(0, 255));
                exp_q.push_back(d);
                bus.mem_we = 1'b1;
                bus.mem_addr = ADDR_TX_DATA;
                bus.mem_wdata = d;
                pushed++;
            end else begin
                bus.mem_we = 1'b0;
            end
            step();
        end
        bus.mem_we = 1'b0;
        bus.tx_ready = 1'b0;
        check("wrap_pushed", 32'(pushed), 32'd20);
        check("wrap_empty",  32'(bus.tx_empty), 32'd1);
        check("wrap_queue",  32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
